// File: rtl/debug_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : debug_spi_tx
// Purpose  : Buffers captured CPU debug bytes in a FIFO and shifts them out
//            to an external SPI master (mode 0, MSB first). The SPI clock and
//            chip select are sampled through 2-flop synchronizers into i_clk.
// Revision : 1.0 - initial release
// ============================================================================
module debug_spi_tx #(
    parameter int         DEPTH     = 16,
    parameter logic [7:0] IDLE_BYTE = 8'h00
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [7:0]                 i_data,
    input  logic                       i_capture,
    input  logic                       i_clr_ovf,
    input  logic                       i_spi_clk,
    input  logic                       i_csn,
    output logic                       o_miso,
    output logic                       o_datasent,
    output logic [$clog2(DEPTH):0]     o_fifo_count,
    output logic                       o_overflow,
    output logic                       o_busy
);

    localparam int               c_AW   = $clog2(DEPTH);
    localparam int               c_CW   = c_AW + 1;
    localparam logic [c_AW:0]    c_FULL = DEPTH[c_AW:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    // Synchronizer chains; stage 3 is the previous synchronized value for edge detection
    logic r_sck_s1, r_sck_s2, r_sck_s3;
    logic r_csn_s1, r_csn_s2, r_csn_s3;

    // FIFO storage
    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_overflow;

    // Shifter state
    state_t          r_state;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_cnt;
    logic            r_load_pending;
    logic            r_real;
    logic            r_datasent;

    logic            w_sck_rise;
    logic            w_sck_fall;
    logic            w_csn_fall;
    logic            w_csn_rise;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [7:0]      w_head;

    // SCK edges only count while chip select is (synchronized) low
    assign w_sck_rise = r_sck_s2 & ~r_sck_s3 & ~r_csn_s2;
    assign w_sck_fall = ~r_sck_s2 & r_sck_s3 & ~r_csn_s2;
    assign w_csn_fall = ~r_csn_s2 & r_csn_s3;
    assign w_csn_rise = r_csn_s2 & ~r_csn_s3;

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];

    // Pop is decided combinationally so a simultaneous push into a full FIFO can use the freed slot
    assign w_pop  = (r_state == S_SHIFT) & w_sck_rise & (r_bit_cnt == 3'd7) & r_real;
    assign w_push = i_capture & (~w_full | w_pop);
    assign w_drop = i_capture & w_full & ~w_pop;

    assign o_miso       = r_shift[7];
    assign o_datasent   = r_datasent;
    assign o_fifo_count = r_count;
    assign o_overflow   = r_overflow;
    assign o_busy       = (r_state != S_IDLE);

    // Two-flop synchronizers plus one history stage; idle levels are CS high, SCK low
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sck_s1 <= 1'b0;
            r_sck_s2 <= 1'b0;
            r_sck_s3 <= 1'b0;
            r_csn_s1 <= 1'b1;
            r_csn_s2 <= 1'b1;
            r_csn_s3 <= 1'b1;
        end else begin
            r_sck_s1 <= i_spi_clk;
            r_sck_s2 <= r_sck_s1;
            r_sck_s3 <= r_sck_s2;
            r_csn_s1 <= i_csn;
            r_csn_s2 <= r_csn_s1;
            r_csn_s3 <= r_csn_s2;
        end
    end

    // FIFO data array; contents are don't-care until written, so no reset
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow (a drop outranks a clear)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Frame state machine: load a byte on CS fall, shift on SCK fall, pop after the 8th SCK rise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_shift        <= 8'h00;
            r_bit_cnt      <= 3'd0;
            r_load_pending <= 1'b0;
            r_real         <= 1'b0;
            r_datasent     <= 1'b0;
        end else begin
            r_datasent <= w_pop;
            if (w_csn_rise) begin
                // Aborted frame: the head byte stays in the FIFO
                r_state        <= S_IDLE;
                r_shift        <= 8'h00;
                r_bit_cnt      <= 3'd0;
                r_load_pending <= 1'b0;
                r_real         <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_shift <= 8'h00;
                        if (w_csn_fall) begin
                            r_state <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        r_shift        <= w_empty ? IDLE_BYTE : w_head;
                        r_real         <= ~w_empty;
                        r_bit_cnt      <= 3'd0;
                        r_load_pending <= 1'b0;
                        r_state        <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (w_sck_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_load_pending <= 1'b1;
                            end
                        end else if (w_sck_fall) begin
                            if (r_load_pending) begin
                                // Head has already advanced past the byte just sent
                                r_shift        <= w_empty ? IDLE_BYTE : w_head;
                                r_real         <= ~w_empty;
                                r_bit_cnt      <= 3'd0;
                                r_load_pending <= 1'b0;
                            end else begin
                                r_shift <= {r_shift[6:0], 1'b0};
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_debug_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_spi_tx
// Purpose  : Self-checking bench for debug_spi_tx: a cycle table for the FIFO
//            push/overflow path, then directed SPI frames for shifting corners.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_spi_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] data;
    logic       capture;
    logic       clr_ovf;
    logic       spi_clk;
    logic       csn;
    logic       miso;
    logic       datasent;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int ds_cnt   = 0;

    typedef struct {
        logic       cap;
        logic [7:0] din;
        logic       clr;
        logic [4:0] exp_count;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl [21];

    debug_spi_tx #(
        .DEPTH     (16),
        .IDLE_BYTE (8'h00)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_data       (data),
        .i_capture    (capture),
        .i_clr_ovf    (clr_ovf),
        .i_spi_clk    (spi_clk),
        .i_csn        (csn),
        .o_miso       (miso),
        .o_datasent   (datasent),
        .o_fifo_count (fifo_count),
        .o_overflow   (overflow),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count datasent pulses; a pulse wider than one cycle counts more than once
    always @(negedge clk) begin
        if (datasent === 1'b1) ds_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        data    = d;
        capture = 1'b1;
        @(negedge clk);
        capture = 1'b0;
    endtask

    task automatic cs_low();
        csn = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high();
        csn = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Master side of n SCK periods: sample MISO just before each rising edge.
    // With coinc set, a push is timed to land on the clock where the 8th rise pops.
    task automatic spi_bits(input int n, input bit coinc, input logic [7:0] cdata,
                            output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < n; i++) begin
            b       = {b[6:0], miso};
            spi_clk = 1'b1;
            if (coinc && i == 7) begin
                @(negedge clk);
                @(negedge clk);
                data    = cdata;
                capture = 1'b1;
                @(negedge clk);
                capture = 1'b0;
                repeat (5) @(negedge clk);
            end else begin
                repeat (8) @(negedge clk);
            end
            spi_clk = 1'b0;
            repeat (8) @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] exp_b;
        int         ds0;

        rst_n   = 1'b0;
        data    = 8'h00;
        capture = 1'b0;
        clr_ovf = 1'b0;
        spi_clk = 1'b0;
        csn     = 1'b1;

        // Cycle table: idle, 17 pushes (last one dropped), drop+clear, clear, idle
        tbl[0] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0};
        for (int k = 1; k <= 17; k++) begin
            tbl[k] = '{1'b1, 8'(k), 1'b0, (k > 16) ? 5'd16 : 5'(k), (k == 17)};
        end
        tbl[18] = '{1'b1, 8'hEE, 1'b1, 5'd16, 1'b1};
        tbl[19] = '{1'b0, 8'h00, 1'b1, 5'd16, 1'b0};
        tbl[20] = '{1'b0, 8'h00, 1'b0, 5'd16, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_miso",     {31'd0, miso},     32'd0);
        check("rst_count",    {27'd0, fifo_count}, 32'd0);
        check("rst_ovf",      {31'd0, overflow}, 32'd0);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_datasent", {31'd0, datasent}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 21; i++) begin
            capture = tbl[i].cap;
            data    = tbl[i].din;
            clr_ovf = tbl[i].clr;
            @(negedge clk);
            check($sformatf("tbl%0d_count", i), {27'd0, fifo_count}, {27'd0, tbl[i].exp_count});
            check($sformatf("tbl%0d_ovf", i),   {31'd0, overflow},   {31'd0, tbl[i].exp_ovf});
        end
        capture = 1'b0;
        clr_ovf = 1'b0;

        // First byte out of the overfilled FIFO is the oldest one
        ds0 = ds_cnt;
        cs_low();
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        spi_bits(8, 1'b0, 8'h00, b);
        cs_high();
        check("first_byte", {24'd0, b}, 32'h01);
        check("first_count", {27'd0, fifo_count}, 32'd15);
        check("first_ds", ds_cnt - ds0, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Refill to full, then push coincident with the 8th-edge pop
        push(8'h12);
        check("refull_count", {27'd0, fifo_count}, 32'd16);
        cs_low();
        spi_bits(8, 1'b1, 8'h13, b);
        check("coinc_byte", {24'd0, b}, 32'h02);
        check("coinc_count", {27'd0, fifo_count}, 32'd16);
        check("coinc_ovf", {31'd0, overflow}, 32'd0);
        cs_high();

        // Drain everything: 03..10, 12, 13 with 13 last
        ds0 = ds_cnt;
        cs_low();
        for (int k = 0; k < 16; k++) begin
            exp_b = (k < 14) ? 8'(k + 3) : ((k == 14) ? 8'h12 : 8'h13);
            spi_bits(8, 1'b0, 8'h00, b);
            check($sformatf("drain%0d", k), {24'd0, b}, {24'd0, exp_b});
        end
        cs_high();
        check("drain_count", {27'd0, fifo_count}, 32'd0);
        check("drain_ds", ds_cnt - ds0, 32'd16);

        // Two bytes in one 16-SCK frame
        push(8'hA5);
        push(8'h3C);
        check("two_count0", {27'd0, fifo_count}, 32'd2);
        ds0 = ds_cnt;
        cs_low();
        spi_bits(8, 1'b0, 8'h00, b);
        check("two_byte0", {24'd0, b}, 32'hA5);
        check("two_count1", {27'd0, fifo_count}, 32'd1);
        spi_bits(8, 1'b0, 8'h00, b);
        check("two_byte1", {24'd0, b}, 32'h3C);
        check("two_count2", {27'd0, fifo_count}, 32'd0);
        cs_high();
        check("two_ds", ds_cnt - ds0, 32'd2);

        // Empty FIFO returns the idle byte without a datasent pulse
        ds0 = ds_cnt;
        cs_low();
        spi_bits(8, 1'b0, 8'h00, b);
        cs_high();
        check("empty_byte", {24'd0, b}, 32'h00);
        check("empty_ds", ds_cnt - ds0, 32'd0);
        check("empty_count", {27'd0, fifo_count}, 32'd0);

        // Aborted frame keeps the byte at the head
        push(8'h81);
        ds0 = ds_cnt;
        cs_low();
        spi_bits(5, 1'b0, 8'h00, b);
        cs_high();
        check("abort_bits", {24'd0, b}, 32'h10);
        check("abort_ds", ds_cnt - ds0, 32'd0);
        check("abort_count", {27'd0, fifo_count}, 32'd1);
        cs_low();
        spi_bits(8, 1'b0, 8'h00, b);
        cs_high();
        check("resend_byte", {24'd0, b}, 32'h81);
        check("resend_count", {27'd0, fifo_count}, 32'd0);
        check("resend_ds", ds_cnt - ds0, 32'd1);

        // Reset mid-frame discards FIFO and frame
        push(8'hF0);
        push(8'h0F);
        cs_low();
        spi_bits(3, 1'b0, 8'h00, b);
        csn   = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy",  {31'd0, busy},       32'd0);
        check("midrst_count", {27'd0, fifo_count}, 32'd0);
        check("midrst_miso",  {31'd0, miso},       32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("after_rst_busy", {31'd0, busy}, 32'd0);
        cs_low();
        spi_bits(8, 1'b0, 8'h00, b);
        cs_high();
        check("after_rst_byte", {24'd0, b}, 32'h00);
        check("after_rst_count", {27'd0, fifo_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debug_spi_tx.md
DEBUG_SPI_TX -- requirements
Module: debug_spi_tx

Parameters
REQ-001 The block SHALL have parameter DEPTH, default 16, the FIFO depth in bytes; it SHALL be a power of two, at least 2.
REQ-002 The block SHALL have parameter IDLE_BYTE, default 8'h00, the byte shifted out when the FIFO is empty.

Interface
REQ-003 The block SHALL have port i_clk, input, 1 bit: system clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port i_data, input, 8 bits: captured CPU debug instruction byte.
REQ-006 The block SHALL have port i_capture, input, 1 bit: single-cycle push strobe, synchronous to i_clk.
REQ-007 The block SHALL have port i_clr_ovf, input, 1 bit: synchronous clear of o_overflow.
REQ-008 The block SHALL have port i_spi_clk, input, 1 bit: external SPI master clock, asynchronous to i_clk.
REQ-009 The block SHALL have port i_csn, input, 1 bit: SPI chip select, active-low, asynchronous.
REQ-010 The block SHALL have port o_miso, output, 1 bit: serial data to the master.
REQ-011 The block SHALL have port o_datasent, output, 1 bit: one-cycle pulse when a FIFO byte has been fully shifted out.
REQ-012 The block SHALL have port o_fifo_count, output, $clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-013 The block SHALL have port o_overflow, output, 1 bit: sticky flag, set when a push was dropped.
REQ-014 The block SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The block SHALL pass i_spi_clk and i_csn through 2-flop synchronizers and detect edges only on the synchronized values; i_clk SHALL be at least 8x the SPI clock rate.
REQ-016 Push: when i_capture=1 and the FIFO is not full, i_data SHALL be written, and o_fifo_count SHALL increment on the following cycle.
REQ-017 Push when full with no pop in the same cycle: the byte SHALL be dropped, the count SHALL be unchanged, and o_overflow SHALL be set to 1.
REQ-018 Push and pop in the same cycle SHALL both succeed at any occupancy, count unchanged; when full, o_overflow SHALL NOT be set.
REQ-019 Clearing o_overflow: i_clr_ovf=1 SHALL clear it; if a drop happens in the same cycle, set SHALL win.
REQ-020 SPI mode SHALL be 0 (CPOL=0, CPHA=0), MSB first, and o_miso SHALL always equal shift_reg[7].
REQ-021 The state machine SHALL have the states IDLE, LOAD and SHIFT.
REQ-022 IDLE: shift_reg SHALL hold 0, and a synchronized i_csn falling edge SHALL move to LOAD.
REQ-023 LOAD (1 cycle): shift_reg SHALL take the FIFO head if the FIFO is non-empty (real=1), else IDLE_BYTE (real=0); bit_cnt SHALL clear to 0; next state SHALL be SHIFT.
REQ-024 SHIFT, on each synchronized SCK rising edge, bit_cnt SHALL increment.
REQ-025 SHIFT, 8th rising edge: if real=1, the FIFO SHALL pop and o_datasent SHALL pulse for 1 cycle; load_pending SHALL be set.
REQ-026 SHIFT, SCK falling edge: with load_pending set, the next byte SHALL load exactly as in LOAD (head or IDLE_BYTE) and load_pending SHALL clear; otherwise shift_reg SHALL shift left by one, filling with 0.
REQ-027 A synchronized i_csn rising edge in any state SHALL return to IDLE, clear bit_cnt and load_pending, and SHALL NOT pop; a partially sent byte SHALL remain at the FIFO head.
REQ-028 SCK edges SHALL be ignored while i_csn is synchronized high.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH, and o_fifo_count SHALL range over 0..DEPTH.

Reset
REQ-030 While i_rst_n=0, the block SHALL hold state=IDLE; pointers, count, bit_cnt, load_pending and shift_reg at 0; o_miso, o_datasent, o_overflow and o_busy at 0; synchronizers at i_csn=1 and SCK=0.
REQ-031 Reset asserted mid-frame SHALL discard FIFO contents and the current frame.
REQ-032 After release, the block SHALL wait for a fresh i_csn falling edge before starting a frame.

Verification
REQ-033 Reset with i_csn held high: o_miso=0, o_fifo_count=0, o_overflow=0, o_busy=0.
REQ-034 Push 8'hA5 then 8'h3C, then 16 SCK cycles with CS low: master samples 10100101 00111100; o_datasent pulses twice; count goes 2 -> 1 -> 0.
REQ-035 Empty FIFO, 8 SCK cycles: master samples 8'h00; o_datasent stays 0; count stays 0.
REQ-036 Push 17 bytes 8'h01..8'h11 with no reads: count=16, o_overflow=1; the first byte read is 8'h01; i_clr_ovf then clears o_overflow.
REQ-037 Push 8'h81, then deassert CS after 5 SCK: no o_datasent, count stays 1; the next full frame returns 8'h81.
REQ-038 FIFO full, push coincident with the 8th-edge pop: count stays 16, o_overflow=0, and the pushed byte is the last one read out.
